// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath constants, opcodes and divider state type
package cpu_pkg;

   localparam int DIV_WIDTH = 32;

   typedef logic [4:0] opcode_t;

   localparam opcode_t OP_ADD = 5'b00011;
   localparam opcode_t OP_SUB = 5'b00100;
   localparam opcode_t OP_MUL = 5'b01111;
   localparam opcode_t OP_DIV = 5'b10000;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ITER,
      FIXUP,
      DONE
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
module div_step
   import cpu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] next_a,
   output logic [WIDTH-1:0] next_q
);

   logic [WIDTH:0]   a_sh;
   logic [WIDTH-1:0] diff;
   logic             ge;

   // The subtraction only needs WIDTH bits: when it is kept the result is below m.
   always_comb begin
      a_sh   = {a, q[WIDTH-1]};
      ge     = (a_sh >= {1'b0, m});
      diff   = a_sh[WIDTH-1:0] - m;
      next_a = ge ? diff : a_sh[WIDTH-1:0];
      next_q = {q[WIDTH-2:0], ge};
   end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle signed restoring divider feeding the Z register
module div_seq
   import cpu_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             Clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   div_state_t       state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic             neg_n;
   logic             neg_d;

   logic [WIDTH-1:0] step_a;
   logic [WIDTH-1:0] step_q;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;

   assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

   div_step #(.WIDTH(WIDTH)) u_step (
      .a      (a),
      .q      (q),
      .m      (m),
      .next_a (step_a),
      .next_q (step_q)
   );

   // q holds |dividend| from acceptance, so the raw dividend is rebuilt from it on divide by zero.
   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         state       <= IDLE;
         count       <= '0;
         a           <= '0;
         q           <= '0;
         m           <= '0;
         neg_n       <= 1'b0;
         neg_d       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  q           <= dvd_mag;
                  m           <= dvs_mag;
                  neg_n       <= dividend[WIDTH-1];
                  neg_d       <= divisor[WIDTH-1];
                  div_by_zero <= 1'b0;
                  busy        <= 1'b1;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               if (m == '0) begin
                  quotient    <= '1;
                  remainder   <= neg_n ? -q : q;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  state       <= DONE;
               end else begin
                  a     <= '0;
                  count <= CNT_LAST;
                  state <= ITER;
               end
            end
            ITER: begin
               a <= step_a;
               q <= step_q;
               if (count == '0) begin
                  state <= FIXUP;
               end else begin
                  count <= count - 1'b1;
               end
            end
            FIXUP: begin
               quotient  <= (neg_n ^ neg_d) ? -q : q;
               remainder <= neg_n ? -a : a;
               done      <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq against a plain-arithmetic model
module tb_div_seq;

   logic        Clock;
   logic        clear;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int errors = 0;
   int checks = 0;

   div_seq #(.WIDTH(32)) dut (
      .Clock       (Clock),
      .clear       (clear),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // C-style signed division: truncation toward zero, remainder follows the dividend.
   task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] eq, output logic [31:0] er,
                          output logic ez, output int elat);
      longint sx, sy, qq, rr;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (sy == 0) begin
         eq = 32'hFFFF_FFFF;
         er = x;
         ez = 1'b1;
         elat = 1;
      end else begin
         qq = sx / sy;
         rr = sx % sy;
         eq = qq[31:0];
         er = rr[31:0];
         ez = 1'b0;
         elat = 34;
      end
   endtask

   // Issues one division, waits (bounded) for done, captures results, then steps back to IDLE.
   task automatic run_div(input logic [31:0] x, input logic [31:0] y, input int change_at,
                          output logic [31:0] gq, output logic [31:0] gr,
                          output logic gz, output int lat);
      int cyc;
      @(negedge Clock);
      dividend = x;
      divisor  = y;
      start    = 1'b1;
      @(posedge Clock);
      #1;
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 100) begin
         @(posedge Clock);
         #1;
         cyc++;
         if (cyc == change_at) begin
            dividend = $urandom;
            divisor  = $urandom;
         end
      end
      lat = cyc;
      gq  = quotient;
      gr  = remainder;
      gz  = div_by_zero;
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset;
      logic [31:0] gq, gr;
      logic        gz;
      int          lat;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
      checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", div_by_zero); end
      // populate the outputs so that the mid-ITER clear has something to wipe
      run_div(32'd1000, 32'd7, -1, gq, gr, gz, lat);
      checks++; if (gq !== 32'd142 || gr !== 32'd6) begin errors++; $display("FAIL pre_clear_div got=%h/%h exp=0000008e/00000006", gq, gr); end
      @(negedge Clock);
      dividend = 32'd12345;
      divisor  = 32'd11;
      start    = 1'b1;
      @(posedge Clock);
      #1;
      start = 1'b0;
      repeat (10) @(posedge Clock);
      #1;
      clear = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL clear_done got=%b exp=0", done); end
      checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL clear_quotient got=%h exp=0", quotient); end
      checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL clear_remainder got=%h exp=0", remainder); end
      @(negedge Clock);
      clear = 1'b0;
      run_div(32'd12345, 32'd11, -1, gq, gr, gz, lat);
      checks++; if (gq !== 32'd1122 || gr !== 32'd3 || gz !== 1'b0) begin
         errors++; $display("FAIL post_clear_div got=%h/%h/%b exp=00000462/00000003/0", gq, gr, gz);
      end
      checks++; if (lat !== 34) begin errors++; $display("FAIL post_clear_latency got=%0d exp=34", lat); end
   endtask

   task automatic test_mixed_signs;
      logic [31:0] gq, gr;
      logic        gz;
      int          lat;
      run_div(32'h0000_0014, 32'hFFFF_FFFB, -1, gq, gr, gz, lat);
      checks++; if (lat !== 34) begin errors++; $display("FAIL mixed_latency got=%0d exp=34", lat); end
      checks++; if (gq !== 32'hFFFF_FFFC) begin errors++; $display("FAIL mixed_quotient got=%h exp=fffffffc", gq); end
      checks++; if (gr !== 32'h0) begin errors++; $display("FAIL mixed_remainder got=%h exp=00000000", gr); end
      checks++; if (gz !== 1'b0) begin errors++; $display("FAIL mixed_dz got=%b exp=0", gz); end
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL mixed_after_done got done=%b busy=%b exp=0/0", done, busy);
      end
   endtask

   task automatic test_remainder_sign;
      logic [31:0] gq, gr;
      logic        gz;
      int          lat;
      run_div(32'hFFFF_FFF9, 32'd2, -1, gq, gr, gz, lat);
      checks++; if (gq !== 32'hFFFF_FFFD || gr !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL neg7_div2 got=%h/%h exp=fffffffd/ffffffff", gq, gr);
      end
      run_div(32'd7, 32'hFFFF_FFFE, -1, gq, gr, gz, lat);
      checks++; if (gq !== 32'hFFFF_FFFD || gr !== 32'h0000_0001) begin
         errors++; $display("FAIL 7_divneg2 got=%h/%h exp=fffffffd/00000001", gq, gr);
      end
   endtask

   task automatic test_div_zero;
      logic [31:0] gq, gr;
      logic        gz;
      int          lat;
      run_div(32'h0000_0064, 32'h0, -1, gq, gr, gz, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got=%0d exp=1", lat); end
      checks++; if (gq !== 32'hFFFF_FFFF || gr !== 32'h0000_0064 || gz !== 1'b1) begin
         errors++; $display("FAIL dz_result got=%h/%h/%b exp=ffffffff/00000064/1", gq, gr, gz);
      end
      checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_held got=%b exp=1", div_by_zero); end
      run_div(32'd9, 32'd3, -1, gq, gr, gz, lat);
      checks++; if (gz !== 1'b0 || gq !== 32'd3) begin errors++; $display("FAIL dz_cleared got=%b/%h exp=0/00000003", gz, gq); end
   endtask

   task automatic test_overflow;
      logic [31:0] gq, gr;
      logic        gz;
      int          lat;
      run_div(32'h8000_0000, 32'hFFFF_FFFF, -1, gq, gr, gz, lat);
      checks++; if (gq !== 32'h8000_0000 || gr !== 32'h0 || gz !== 1'b0) begin
         errors++; $display("FAIL overflow got=%h/%h/%b exp=80000000/00000000/0", gq, gr, gz);
      end
   endtask

   task automatic test_handshake;
      int pulses, first, second;
      logic [31:0] eq, er;
      logic        ez;
      int          elat;
      ref_div(32'd100003, 32'hFFFF_FFF3, eq, er, ez, elat);
      @(negedge Clock);
      dividend = 32'd100003;
      divisor  = 32'hFFFF_FFF3;
      start    = 1'b1;
      @(posedge Clock);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_busy_rise got=%b exp=1", busy); end
      pulses = 0; first = -1; second = -1;
      for (int c = 1; c <= 71; c++) begin
         @(posedge Clock);
         #1;
         if (done === 1'b1) begin
            pulses++;
            if (first < 0) first = c; else if (second < 0) second = c;
         end
      end
      start = 1'b0;
      checks++; if (pulses !== 2) begin errors++; $display("FAIL hs_pulse_count got=%0d exp=2", pulses); end
      checks++; if (first !== 34 || second !== 70) begin
         errors++; $display("FAIL hs_pulse_times got=%0d,%0d exp=34,70", first, second);
      end
      checks++; if (quotient !== eq || remainder !== er) begin
         errors++; $display("FAIL hs_result got=%h/%h exp=%h/%h", quotient, remainder, eq, er);
      end
      @(posedge Clock);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_operand_change;
      logic [31:0] gq, gr, eq, er;
      logic        gz, ez;
      int          lat, elat;
      ref_div(32'hDEAD_BEEF, 32'h0000_1234, eq, er, ez, elat);
      run_div(32'hDEAD_BEEF, 32'h0000_1234, 12, gq, gr, gz, lat);
      checks++; if (gq !== eq || gr !== er || gz !== ez) begin
         errors++; $display("FAIL opchange got=%h/%h/%b exp=%h/%h/%b", gq, gr, gz, eq, er, ez);
      end
   endtask

   task automatic test_random;
      logic [31:0] x, y, gq, gr, eq, er;
      logic        gz, ez;
      int          lat, elat;
      for (int i = 0; i < 24; i++) begin
         x = $urandom;
         case ($urandom_range(0, 3))
            0: y = $urandom;
            1: y = 32'($signed($urandom_range(0, 40)) - 20);
            2: begin y = $urandom; x = 32'h8000_0000; end
            default: y = $urandom >> $urandom_range(0, 31);
         endcase
         ref_div(x, y, eq, er, ez, elat);
         run_div(x, y, -1, gq, gr, gz, lat);
         checks++;
         if (gq !== eq || gr !== er || gz !== ez || lat !== elat) begin
            errors++;
            $display("FAIL random x=%h y=%h got=%h/%h/%b lat=%0d exp=%h/%h/%b lat=%0d",
                     x, y, gq, gr, gz, lat, eq, er, ez, elat);
         end
      end
   endtask

   initial begin
      clear    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge Clock);
      #1;
      test_reset_wrapper();
      test_mixed_signs();
      test_remainder_sign();
      test_div_zero();
      test_overflow();
      test_handshake();
      test_operand_change();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   task automatic test_reset_wrapper;
      @(negedge Clock);
      test_reset_initial_values();
      clear = 1'b0;
      test_reset();
   endtask

   task automatic test_reset_initial_values;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL held_reset got busy=%b done=%b exp=0/0", busy, done);
      end
   endtask

endmodule
